// File: rtl/puf_pkg.sv
// Shared widths and FSM state encoding for the RO-PUF challenge sequencer.
package puf_pkg;

    localparam int unsigned CHAL_W = 8;
    localparam int unsigned RESP_W = 16;
    localparam int unsigned VOTE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        EVAL,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/puf_bit_voter.sv
// Per-bit vote accumulator for one RO response bit across NVOTE evaluations.
module puf_bit_voter
    import puf_pkg::*;
#(
    parameter int unsigned NVOTE = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc_en,
    input  logic              bit_in,
    output logic [VOTE_W-1:0] vote_cnt,
    output logic              majority,
    output logic              unanimous
);

    localparam logic [VOTE_W-1:0] HALF = VOTE_W'(NVOTE / 2);
    localparam logic [VOTE_W-1:0] ALL  = VOTE_W'(NVOTE);

    logic [VOTE_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = vote_cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc_en && bit_in) begin
            cnt_nxt = vote_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_cnt <= '0;
        end else begin
            vote_cnt <= cnt_nxt;
        end
    end

    // Decisions look at the post-increment count so the final SAMPLE cycle can
    // register the result directly into the DONE cycle.
    assign majority  = (cnt_nxt > HALF);
    assign unanimous = (cnt_nxt == '0) || (cnt_nxt == ALL);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives the 16-RO PUF array through NVOTE clear/evaluate/sample rounds and
// publishes the majority-voted response with a unanimity flag.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int unsigned CLR_CYCLES  = 4,
    parameter int unsigned EVAL_CYCLES = 1000,
    parameter int unsigned NVOTE       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_in,
    input  logic [RESP_W-1:0] resp_in,
    output logic              en_out,
    output logic              ro_clr,
    output logic [CHAL_W-1:0] challenge_out,
    output logic [RESP_W-1:0] resp_out,
    output logic              resp_valid,
    output logic              stable,
    output logic              busy
);

    localparam logic [15:0]       CLR_LOAD   = 16'(CLR_CYCLES - 1);
    localparam logic [15:0]       EVAL_LOAD  = 16'(EVAL_CYCLES - 1);
    localparam logic [VOTE_W-1:0] LAST_ROUND = VOTE_W'(NVOTE - 1);

    state_t              state;
    logic [15:0]         timer;
    logic [VOTE_W-1:0]   round;
    logic [RESP_W-1:0]   sync1;
    logic [RESP_W-1:0]   sync2;
    logic [RESP_W-1:0]   maj;
    logic [RESP_W-1:0]   una;
    logic [RESP_W*VOTE_W-1:0] vote_cnt_unused;
    logic                vclr;
    logic                vinc;

    assign vclr = (state == IDLE) && start;
    assign vinc = (state == SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= resp_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < RESP_W; i++) begin : g_vote
        puf_bit_voter #(.NVOTE(NVOTE)) u_voter (
            .clk      (clk),
            .rst      (rst),
            .clr      (vclr),
            .inc_en   (vinc),
            .bit_in   (sync2[i]),
            .vote_cnt (vote_cnt_unused[i*VOTE_W +: VOTE_W]),
            .majority (maj[i]),
            .unanimous(una[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            round         <= '0;
            en_out        <= 1'b0;
            ro_clr        <= 1'b0;
            challenge_out <= '0;
            resp_out      <= '0;
            resp_valid    <= 1'b0;
            stable        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        challenge_out <= challenge_in;
                        round         <= '0;
                        timer         <= CLR_LOAD;
                        ro_clr        <= 1'b1;
                        busy          <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (timer == '0) begin
                        ro_clr <= 1'b0;
                        en_out <= 1'b1;
                        timer  <= EVAL_LOAD;
                        state  <= EVAL;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                EVAL: begin
                    if (timer == '0) begin
                        en_out <= 1'b0;
                        timer  <= 16'd1;
                        state  <= HOLD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        state <= SAMPLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SAMPLE: begin
                    round <= round + 1'b1;
                    if (round == LAST_ROUND) begin
                        resp_out   <= maj;
                        stable     <= &una;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ro_clr <= 1'b1;
                        timer  <= CLR_LOAD;
                        state  <= CLEAR;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with CLR=2, EVAL=8, NVOTE=3.
module tb_puf_challenge_sequencer;

    localparam int unsigned C   = 2;
    localparam int unsigned E   = 8;
    localparam int unsigned N   = 3;
    localparam int          LAT = int'(N * (C + E + 3));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  challenge_in = '0;
    logic [15:0] resp_in = '0;
    logic        en_out, ro_clr, resp_valid, stable, busy;
    logic [7:0]  challenge_out;
    logic [15:0] resp_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    typedef struct {
        logic [15:0] resp;
        logic        stab;
        int          at;
    } exp_t;
    exp_t sb[$];

    puf_challenge_sequencer #(
        .CLR_CYCLES (C),
        .EVAL_CYCLES(E),
        .NVOTE      (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .challenge_in (challenge_in),
        .resp_in      (resp_in),
        .en_out       (en_out),
        .ro_clr       (ro_clr),
        .challenge_out(challenge_out),
        .resp_out     (resp_out),
        .resp_valid   (resp_valid),
        .stable       (stable),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns just after the accepting edge (cycle 1).
    task automatic issue(input logic [7:0] chal, input logic [15:0] r, input logic s, input bit track);
        start = 1'b1;
        challenge_in = chal;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = cyc;
        if (track) sb.push_back('{r, s, base + LAT});
    endtask

    // Advance to the negedge of cycle n of the current operation.
    task automatic go(input int n);
        do @(negedge clk); while (cyc < base + n - 1);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got resp_out=%0h with no pending request (cyc %0d)", resp_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_out", 32'(resp_out), 32'(e.resp));
                chk("stable", 32'(stable), 32'(e.stab));
                chk("valid_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int clr_n, en_n, busy_n, first_en;
        @(negedge clk);
        chk("reset_outputs", {7'd0, en_out, ro_clr, busy, resp_valid, stable, challenge_out, resp_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic run, with start pulses while busy and in the DONE cycle.
        resp_in = 16'hA5C3;
        issue(8'h5A, 16'hA5C3, 1'b1, 1'b1);
        chk("chal_latch", 32'(challenge_out), 32'h5A);
        clr_n = 0; en_n = 0; busy_n = 0; first_en = 0;
        for (int n = 1; n <= 40; n++) begin
            go(n);
            clr_n  += int'(ro_clr);
            en_n   += int'(en_out);
            busy_n += int'(busy);
            if (en_out && first_en == 0) first_en = n;
            if (n == 5 || n == 20 || n == 40) begin
                start = 1'b1;
                challenge_in = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        chk("ro_clr_cycles", clr_n, 6);
        chk("en_out_cycles", en_n, 24);
        chk("busy_cycles", busy_n, 40);
        chk("first_en_cycle", first_en, 3);
        go(41);
        start = 1'b0;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("chal_held", 32'(challenge_out), 32'h5A);

        // Back-to-back start in the cycle after DONE.
        resp_in = 16'h1234;
        issue(8'h33, 16'h1234, 1'b1, 1'b1);
        chk("chal_b2b", 32'(challenge_out), 32'h33);
        go(39);
        chk("resp_hold", 32'(resp_out), 32'hA5C3);
        go(41);

        // Majority: all-ones round 1, zeros rounds 2-3.
        resp_in = 16'hFFFF;
        issue(8'h12, 16'h0000, 1'b0, 1'b1);
        go(14);
        resp_in = 16'h0000;
        go(41);

        // Per-bit vote: bit 0 set in rounds 1-2 only.
        resp_in = 16'h0001;
        issue(8'h21, 16'h0001, 1'b0, 1'b1);
        go(27);
        resp_in = 16'h0000;
        go(41);
        chk("resp_perbit_hold", 32'(resp_out), 32'h0001);

        // Reset mid-EVAL aborts without a response.
        resp_in = 16'hFFFF;
        issue(8'h44, 16'h0000, 1'b0, 1'b0);
        go(5);
        chk("in_eval", 32'(en_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_en_out", 32'(en_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_out", 32'(resp_out), 32'd0);
        chk("rst_chal", 32'(challenge_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, en_out}, 32'd0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
